// File: rtl/inv_aes_ctrl.sv
// Round-robin job controller sharing one inv_aes decryption core
// among NREQ requesters, with key reuse and a completion timeout.
module inv_aes_ctrl #(
  parameter int NREQ     = 4,
  parameter int KEY_WAIT = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rest,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*128-1:0] req_data,
  input  logic [NREQ*128-1:0] req_key,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [127:0]        rsp_data,
  output logic                rsp_err,
  output logic                core_start,
  output logic [127:0]        core_data,
  output logic [127:0]        core_key,
  input  logic                core_key_ready,
  input  logic                core_busy,
  input  logic                core_done,
  input  logic [127:0]        core_result,
  output logic                ctrl_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int KW = (KEY_WAIT > 0) ? $clog2(KEY_WAIT + 1) : 1;
  localparam logic [IW:0]   NQ    = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST  = IW'(NREQ - 1);
  localparam logic [TW-1:0] T_END = TW'(TIMEOUT - 2);
  localparam logic [KW-1:0] K_END = KW'(KEY_WAIT);

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   g;
  logic [127:0]    data_r;
  logic [127:0]    key_r;
  logic [127:0]    last_key;
  logic            key_vld;
  logic [KW-1:0]   wcnt;
  logic [TW-1:0]   tcnt;

  logic [2*NREQ-1:0] rv2;
  logic [NREQ-1:0]   rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [127:0]      gnt_data;
  logic [127:0]      gnt_key;

  logic key_hit;
  logic key_wait_done;
  logic tout;
  logic core_fin;

  // Rotate requests so rr_ptr sits at bit 0, then pick the lowest set bit.
  always_comb begin
    rv2     = {req_valid, req_valid} >> rr_ptr;
    rot     = rv2[NREQ-1:0];
    off     = '0;
    gnt_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_any = 1'b1;
        off     = IW'(k);
      end
    end
    sum     = {1'b0, rr_ptr} + {1'b0, off};
    gnt_idx = (sum >= NQ) ? IW'(sum - NQ) : sum[IW-1:0];
  end

  always_comb begin
    gnt_data = '0;
    gnt_key  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IW'(k)) begin
        gnt_data = req_data[128*k +: 128];
        gnt_key  = req_key[128*k +: 128];
      end
    end
  end

  assign key_hit       = key_vld && (key_r == last_key);
  assign key_wait_done = (wcnt >= K_END);
  // tcnt lags core_start by one cycle: T_END lands TIMEOUT-1 after it.
  assign tout          = (tcnt >= T_END);
  assign core_fin      = !core_busy && core_done;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (gnt_any) state_nx = KEY;
      end
      KEY: begin
        if (key_hit || (key_wait_done && core_key_ready))
          state_nx = START;
      end
      START: begin
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tout) state_nx = RESP;
        else if (core_busy) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (core_fin || tout) state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      g        <= '0;
      data_r   <= '0;
      key_r    <= '0;
      last_key <= '0;
      key_vld  <= 1'b0;
      wcnt     <= '0;
      tcnt     <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            g      <= gnt_idx;
            data_r <= gnt_data;
            key_r  <= gnt_key;
            wcnt   <= '0;
          end
        end
        KEY: begin
          if (!key_hit) begin
            if (!key_wait_done) begin
              wcnt <= wcnt + KW'(1);
            end else if (core_key_ready) begin
              last_key <= key_r;
              key_vld  <= 1'b1;
            end
          end
        end
        START: begin
          tcnt <= '0;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (state == WAIT_DONE && core_fin) begin
            rsp_data <= core_result;
            rsp_err  <= 1'b0;
          end else if (tout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            key_vld  <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RESP: begin
          rr_ptr <= (g == LAST) ? '0 : g + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign core_start = (state == START);
  assign core_data  = data_r;
  assign core_key   = key_r;
  assign ctrl_busy  = (state != IDLE);
  assign req_ready  = (state == IDLE && gnt_any && !rest)
                    ? (NREQ'(1) << gnt_idx) : '0;
  assign rsp_valid  = (state == RESP) ? (NREQ'(1) << g) : '0;

endmodule

// File: tb/tb_inv_aes_ctrl.sv
// Randomized bench for inv_aes_ctrl with a behavioural core model
// and a job-level reference model of arbitration and key reuse.
module tb_inv_aes_ctrl;
  localparam int NREQ = 4;
  localparam int KEY_WAIT = 2;
  localparam int TIMEOUT = 64;
  localparam logic [127:0] F_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] F_PT  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rest;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*128-1:0] req_data;
  logic [NREQ*128-1:0] req_key;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] rsp_valid;
  logic [127:0] rsp_data;
  logic rsp_err;
  logic core_start;
  logic [127:0] core_data;
  logic [127:0] core_key;
  logic core_key_ready;
  logic core_busy;
  logic core_done;
  logic [127:0] core_result;
  logic ctrl_busy;

  logic [127:0] d_arr [NREQ];
  logic [127:0] k_arr [NREQ];

  int checks = 0;
  int errs = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_data = '0;
    req_key = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_data[128*k +: 128] = d_arr[k];
      req_key[128*k +: 128] = k_arr[k];
    end
  end

  inv_aes_ctrl #(.NREQ(NREQ), .KEY_WAIT(KEY_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rest(rest),
    .req_valid(req_valid), .req_data(req_data), .req_key(req_key),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_start(core_start), .core_data(core_data), .core_key(core_key),
    .core_key_ready(core_key_ready), .core_busy(core_busy),
    .core_done(core_done), .core_result(core_result),
    .ctrl_busy(ctrl_busy)
  );

  // Stand-in for the decryption core: the FIPS-197 vector, else a keyed mix.
  function automatic logic [127:0] core_fn(logic [127:0] d, logic [127:0] k);
    if (d == F_CT && k == F_KEY) return F_PT;
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
  endfunction

  bit never_busy = 0;
  bit hold_done = 0;
  int bdly_lo = 0, bdly_hi = 3, bdur_lo = 1, bdur_hi = 6;
  logic [127:0] m_prev_key, m_res;
  int m_kcnt, m_cnt, m_phase;

  always @(posedge clk or posedge rest) begin
    if (rest) begin
      core_key_ready <= 0; core_busy <= 0; core_done <= 0;
      core_result <= '0; m_prev_key <= '0; m_res <= '0;
      m_kcnt <= 3; m_cnt <= 0; m_phase <= 0;
    end else begin
      if (core_key !== m_prev_key) begin
        m_prev_key <= core_key;
        core_key_ready <= 0;
        m_kcnt <= $urandom_range(4, 0);
      end else if (m_kcnt > 0) m_kcnt <= m_kcnt - 1;
      else core_key_ready <= 1;
      case (m_phase)
        0: begin
          if (!hold_done) core_done <= 0;
          if (core_start && !never_busy) begin
            m_phase <= 1;
            m_cnt <= $urandom_range(bdly_hi, bdly_lo);
            m_res <= core_fn(core_data, core_key);
          end
        end
        1: if (m_cnt == 0) begin
          core_busy <= 1; core_done <= 0; m_phase <= 2;
          m_cnt <= $urandom_range(bdur_hi, bdur_lo);
        end else m_cnt <= m_cnt - 1;
        default: if (m_cnt == 0) begin
          core_busy <= 0; core_done <= 1;
          core_result <= m_res; m_phase <= 0;
        end else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  logic [NREQ-1:0] g_vec_q[$];
  int g_cyc_q[$];
  int s_cyc_q[$];
  logic s_done_q[$];
  int d_cyc_q[$];
  logic [NREQ-1:0] r_vec_q[$];
  logic [127:0] r_dat_q[$];
  logic r_err_q[$];
  int r_cyc_q[$];
  int busy_n = 0;
  logic mon_done_d = 0;

  always @(negedge clk) begin
    if (|req_ready) begin g_vec_q.push_back(req_ready); g_cyc_q.push_back(cyc); end
    if (core_start) begin s_cyc_q.push_back(cyc); s_done_q.push_back(core_done); end
    if (core_done && !mon_done_d) d_cyc_q.push_back(cyc);
    mon_done_d = core_done;
    if (|rsp_valid) begin
      r_vec_q.push_back(rsp_valid); r_dat_q.push_back(rsp_data);
      r_err_q.push_back(rsp_err); r_cyc_q.push_back(cyc);
    end
    if (ctrl_busy) busy_n++;
  end

  int ref_ptr = 0;
  bit ref_kvld = 0;
  logic [127:0] ref_lkey = '0;

  task automatic model_job(input logic [NREQ-1:0] mask, input logic [127:0] key,
                           input bit aborted, output int idx, output bit hit);
    idx = -1;
    for (int k = 0; k < NREQ; k++)
      if (idx < 0 && mask[(ref_ptr + k) % NREQ]) idx = (ref_ptr + k) % NREQ;
    hit = ref_kvld && (key == ref_lkey);
    ref_ptr = (idx + 1) % NREQ;
    if (aborted) ref_kvld = 0;
    else begin ref_kvld = 1; ref_lkey = key; end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NREQ-1:0] onehot(int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic clear_logs();
    g_vec_q.delete(); g_cyc_q.delete(); s_cyc_q.delete(); s_done_q.delete();
    d_cyc_q.delete(); r_vec_q.delete(); r_dat_q.delete(); r_err_q.delete();
    r_cyc_q.delete(); busy_n = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rest = 1; req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rest = 0;
    ref_ptr = 0; ref_kvld = 0;
  endtask

  task automatic run_job(input int i, input logic [127:0] d, input logic [127:0] k,
                         output bit ok);
    int n;
    ok = 1;
    clear_logs();
    @(posedge clk); #1;
    d_arr[i] = d; k_arr[i] = k; req_valid[i] = 1'b1;
    for (n = 0; n < 200; n++) begin @(negedge clk); if (req_ready[i]) break; end
    if (n == 200) ok = 0;
    @(posedge clk); #1;
    req_valid[i] = 1'b0; d_arr[i] = rand128(); k_arr[i] = rand128();
    for (n = 0; n < TIMEOUT * 4; n++) begin @(negedge clk); if (|rsp_valid) break; end
    if (n == TIMEOUT * 4) ok = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rest = 1; req_valid = '1;
    for (int k = 0; k < NREQ; k++) begin d_arr[k] = rand128(); k_arr[k] = rand128(); end
    repeat (3) @(posedge clk); #1;
    checks++; if (req_ready !== '0) begin errs++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    checks++; if (rsp_valid !== '0) begin errs++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if ({rsp_data, rsp_err} !== '0) begin errs++; $display("FAIL reset_rsp got %h/%b exp 0", rsp_data, rsp_err); end
    checks++; if ({core_data, core_key} !== '0) begin errs++; $display("FAIL reset_core_bus got %h %h exp 0", core_data, core_key); end
    checks++; if ({core_start, ctrl_busy} !== 2'b00) begin errs++; $display("FAIL reset_start_busy got %b%b exp 00", core_start, ctrl_busy); end
    req_valid = '0;
    @(posedge clk); #1 rest = 0;
    ref_ptr = 0; ref_kvld = 0;
  endtask

  task automatic test_fips();
    bit ok, hit; int idx, lat;
    run_job(0, F_CT, F_KEY, ok);
    model_job(4'b0001, F_KEY, 0, idx, hit);
    checks++; if (ok !== 1'b1 || r_vec_q.size() != 1 || s_cyc_q.size() != 1) begin
      errs++; $display("FAIL fips_complete got ok=%0b rsp=%0d exp ok=1 rsp=1", ok, r_vec_q.size());
    end else begin
      lat = s_cyc_q[0] - g_cyc_q[0];
      checks++; if (g_vec_q[0] !== onehot(idx)) begin errs++; $display("FAIL fips_grant got %b exp %b", g_vec_q[0], onehot(idx)); end
      checks++; if (r_vec_q[0] !== onehot(idx)) begin errs++; $display("FAIL fips_rsp_valid got %b exp %b", r_vec_q[0], onehot(idx)); end
      checks++; if (r_dat_q[0] !== F_PT) begin errs++; $display("FAIL fips_rsp_data got %h exp %h", r_dat_q[0], F_PT); end
      checks++; if (r_err_q[0] !== 1'b0) begin errs++; $display("FAIL fips_rsp_err got %b exp 0", r_err_q[0]); end
      checks++; if (hit || lat < KEY_WAIT + 2) begin errs++; $display("FAIL fips_key_miss_latency got %0d exp >=%0d", lat, KEY_WAIT + 2); end
      checks++; if (busy_n != r_cyc_q[0] - g_cyc_q[0]) begin errs++; $display("FAIL fips_ctrl_busy got %0d exp %0d", busy_n, r_cyc_q[0] - g_cyc_q[0]); end
    end
    checks++; if (rsp_data !== F_PT) begin errs++; $display("FAIL fips_rsp_hold got %h exp %h", rsp_data, F_PT); end
  endtask

  task automatic test_round_robin();
    logic [127:0] key; logic [127:0] exp_res[$]; int grants, n, idx, lat; bit hit;
    do_reset();
    clear_logs();
    key = rand128();
    for (int k = 0; k < NREQ; k++) begin k_arr[k] = key; d_arr[k] = rand128(); end
    req_valid = '1;
    grants = 0;
    for (n = 0; n < 3000 && grants < 5; n++) begin
      @(negedge clk);
      if (|req_ready) begin
        idx = -1;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) idx = k;
        exp_res.push_back(core_fn(d_arr[idx], key));
        grants++;
        @(posedge clk); #1;
        d_arr[idx] = rand128();
        if (grants == 5) req_valid = '0;
      end
    end
    req_valid = '0;
    for (n = 0; n < 500 && r_vec_q.size() < 5; n++) @(negedge clk);
    #1;
    checks++; if (r_vec_q.size() != 5 || s_cyc_q.size() != 5 || d_cyc_q.size() != 5) begin
      errs++; $display("FAIL rr_job_count got %0d exp 5", r_vec_q.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        model_job('1, key, 0, idx, hit);
        lat = s_cyc_q[j] - g_cyc_q[j];
        checks++; if (g_vec_q[j] !== onehot(idx)) begin errs++; $display("FAIL rr_grant%0d got %b exp %b", j, g_vec_q[j], onehot(idx)); end
        checks++; if (r_vec_q[j] !== onehot(idx)) begin errs++; $display("FAIL rr_rsp_valid%0d got %b exp %b", j, r_vec_q[j], onehot(idx)); end
        checks++; if ({r_dat_q[j], r_err_q[j]} !== {exp_res[j], 1'b0}) begin errs++; $display("FAIL rr_rsp%0d got %h/%b exp %h/0", j, r_dat_q[j], r_err_q[j], exp_res[j]); end
        checks++; if (hit ? (lat != 2) : (lat < KEY_WAIT + 2)) begin errs++; $display("FAIL rr_latency%0d got %0d exp %s", j, lat, hit ? "2" : ">=KEY_WAIT+2"); end
        checks++; if (r_cyc_q[j] != d_cyc_q[j] + 1) begin errs++; $display("FAIL rr_done_to_rsp%0d got %0d exp 1", j, r_cyc_q[j] - d_cyc_q[j]); end
      end
    end
  endtask

  task automatic test_key_alternate();
    logic [127:0] k1, k3, key, d; bit ok, hit; int i, idx, lat;
    k1 = rand128(); k3 = ~k1;
    for (int j = 0; j < 6; j++) begin
      i = (j % 2 == 0) ? 1 : 3;
      key = (i == 1) ? k1 : k3;
      d = rand128();
      run_job(i, d, key, ok);
      model_job(onehot(i), key, 0, idx, hit);
      checks++; if (ok !== 1'b1 || r_vec_q.size() != 1) begin
        errs++; $display("FAIL alt_complete%0d got ok=%0b exp 1", j, ok);
      end else begin
        lat = s_cyc_q[0] - g_cyc_q[0];
        checks++; if (hit || lat < KEY_WAIT + 2) begin errs++; $display("FAIL alt_key_miss%0d got lat %0d exp >=%0d", j, lat, KEY_WAIT + 2); end
        checks++; if (r_vec_q[0] !== onehot(idx)) begin errs++; $display("FAIL alt_rsp_valid%0d got %b exp %b", j, r_vec_q[0], onehot(idx)); end
        checks++; if ({r_dat_q[0], r_err_q[0]} !== {core_fn(d, key), 1'b0}) begin errs++; $display("FAIL alt_rsp%0d got %h/%b exp %h/0", j, r_dat_q[0], r_err_q[0], core_fn(d, key)); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [127:0] key, d; bit ok, hit; int idx;
    key = rand128();
    run_job(2, rand128(), key, ok);
    model_job(onehot(2), key, 0, idx, hit);
    never_busy = 1;
    d = rand128();
    run_job(2, d, key, ok);
    model_job(onehot(2), key, 1, idx, hit);
    never_busy = 0;
    checks++; if (ok !== 1'b1 || r_vec_q.size() != 1 || s_cyc_q.size() != 1) begin
      errs++; $display("FAIL to_complete got ok=%0b exp 1", ok);
    end else begin
      checks++; if (!hit || s_cyc_q[0] - g_cyc_q[0] != 2) begin errs++; $display("FAIL to_hit_latency got %0d exp 2", s_cyc_q[0] - g_cyc_q[0]); end
      checks++; if ({r_dat_q[0], r_err_q[0]} !== {128'h0, 1'b1}) begin errs++; $display("FAIL to_rsp got %h/%b exp 0/1", r_dat_q[0], r_err_q[0]); end
      checks++; if (r_cyc_q[0] - s_cyc_q[0] != TIMEOUT) begin errs++; $display("FAIL to_abort_time got %0d exp %0d", r_cyc_q[0] - s_cyc_q[0], TIMEOUT); end
    end
    d = rand128();
    run_job(2, d, key, ok);
    model_job(onehot(2), key, 0, idx, hit);
    checks++; if (ok !== 1'b1 || r_vec_q.size() != 1) begin
      errs++; $display("FAIL to_next_complete got ok=%0b exp 1", ok);
    end else begin
      checks++; if (hit || s_cyc_q[0] - g_cyc_q[0] < KEY_WAIT + 2) begin errs++; $display("FAIL to_next_key_miss got %0d exp >=%0d", s_cyc_q[0] - g_cyc_q[0], KEY_WAIT + 2); end
      checks++; if ({r_dat_q[0], r_err_q[0]} !== {core_fn(d, key), 1'b0}) begin errs++; $display("FAIL to_next_rsp got %h/%b exp %h/0", r_dat_q[0], r_err_q[0], core_fn(d, key)); end
    end
  endtask

  task automatic test_hold_done();
    logic [127:0] key, da, db; bit ok, hit; int idx;
    hold_done = 1; bdly_lo = 4; bdly_hi = 4;
    key = rand128(); da = rand128(); db = rand128();
    run_job(0, da, key, ok);
    model_job(onehot(0), key, 0, idx, hit);
    run_job(0, db, key, ok);
    model_job(onehot(0), key, 0, idx, hit);
    checks++; if (ok !== 1'b1 || r_vec_q.size() != 1 || s_cyc_q.size() != 1) begin
      errs++; $display("FAIL hold_complete got ok=%0b exp 1", ok);
    end else begin
      checks++; if (s_done_q[0] !== 1'b1) begin errs++; $display("FAIL hold_done_at_start got %b exp 1", s_done_q[0]); end
      checks++; if ({r_dat_q[0], r_err_q[0]} !== {core_fn(db, key), 1'b0}) begin errs++; $display("FAIL hold_rsp got %h/%b exp %h/0", r_dat_q[0], r_err_q[0], core_fn(db, key)); end
      checks++; if (r_cyc_q[0] - s_cyc_q[0] < 7) begin errs++; $display("FAIL hold_early got %0d exp >=7", r_cyc_q[0] - s_cyc_q[0]); end
    end
    hold_done = 0; bdly_lo = 0; bdly_hi = 3;
  endtask

  task automatic test_reset_mid();
    logic [127:0] key, d; bit ok, hit; int n, idx;
    bdur_lo = 20; bdur_hi = 20;
    clear_logs();
    @(posedge clk); #1;
    d_arr[2] = rand128(); k_arr[2] = rand128(); req_valid[2] = 1'b1;
    for (n = 0; n < 200; n++) begin @(negedge clk); if (req_ready[2]) break; end
    @(posedge clk); #1 req_valid[2] = 1'b0;
    for (n = 0; n < 200; n++) begin @(negedge clk); if (core_busy) break; end
    checks++; if (core_busy !== 1'b1) begin errs++; $display("FAIL mid_reach_busy got %b exp 1", core_busy); end
    repeat (2) @(posedge clk);
    #1 rest = 1;
    #1;
    checks++; if ({req_ready, rsp_valid, core_start, ctrl_busy} !== '0) begin errs++; $display("FAIL mid_reset_ctl got %b %b %b %b exp 0", req_ready, rsp_valid, core_start, ctrl_busy); end
    checks++; if ({rsp_data, rsp_err, core_data, core_key} !== '0) begin errs++; $display("FAIL mid_reset_data got %h %b exp 0", rsp_data, rsp_err); end
    repeat (2) @(posedge clk);
    #1 rest = 0;
    ref_ptr = 0; ref_kvld = 0;
    bdur_lo = 1; bdur_hi = 6;
    clear_logs();
    repeat (40) @(negedge clk);
    checks++; if (r_vec_q.size() != 0 || g_vec_q.size() != 0) begin errs++; $display("FAIL mid_no_rsp got %0d exp 0", r_vec_q.size()); end
    key = rand128(); d = rand128();
    run_job(1, d, key, ok);
    model_job(onehot(1), key, 0, idx, hit);
    checks++; if (ok !== 1'b1 || r_vec_q.size() != 1) begin
      errs++; $display("FAIL mid_after_complete got ok=%0b exp 1", ok);
    end else begin
      checks++; if (r_vec_q[0] !== onehot(idx)) begin errs++; $display("FAIL mid_after_valid got %b exp %b", r_vec_q[0], onehot(idx)); end
      checks++; if ({r_dat_q[0], r_err_q[0]} !== {core_fn(d, key), 1'b0}) begin errs++; $display("FAIL mid_after_rsp got %h/%b exp %h/0", r_dat_q[0], r_err_q[0], core_fn(d, key)); end
    end
  endtask

  initial begin
    rest = 1; req_valid = '0;
    for (int k = 0; k < NREQ; k++) begin d_arr[k] = '0; k_arr[k] = '0; end
    test_reset();
    test_fips();
    test_round_robin();
    test_key_alternate();
    test_timeout();
    test_hold_done();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
